// File: rtl/correlator.sv
// correlator: combinational bit-agreement correlator.
// The result is the number of bit positions where the two 10-bit operands agree (0..10),
// zero-extended to 10 bits.
// Ports:
//   a_i           operand a (10 bits)
//   b_i           operand b (10 bits)
//   correlation_o count of matching bit positions (10 bits)
module correlator (
    input  logic [9:0] a_i,
    input  logic [9:0] b_i,
    output logic [9:0] correlation_o
);

    always_comb begin
        correlation_o = '0;
        for (int i = 0; i < 10; i++) begin
            correlation_o = correlation_o + {9'd0, ~(a_i[i] ^ b_i[i])};
        end
    end

endmodule

// File: rtl/correlation_scheduler.sv
// correlation_scheduler: computes the ab, ac and bc correlations of three operands by
// time-multiplexing one shared correlator over three cycles. The operands are captured on an
// accepted start. Each result is registered as it is produced. A one-cycle done pulse marks
// completion.
//
// Optional feature, enabled by the macro CORR_MAX_TRACK_EN: adds max_pair_o and max_value_o.
// These give the index (0=ab, 1=ac, 2=bc) and the value of the largest result. Ties go to the
// lower index.
//
// Parameters:
//   WIDTH          operand/result width; must be 10 to match the correlator
//   CLEAR_ON_START 1: results clear to 0 on every accepted start; 0: results hold
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-high reset
//   start_i           request a new computation (accepted in IDLE or DONE)
//   a_i, b_i, c_i     operands, sampled only on an accepted start
//   busy_o            high in states AB, AC, BC
//   done_o            one-cycle pulse, all three results updated
//   ab_correlation_o  registered correlator(a, b)
//   ac_correlation_o  registered correlator(a, c)
//   bc_correlation_o  registered correlator(b, c)
//   max_pair_o        (CORR_MAX_TRACK_EN) index of the largest result
//   max_value_o       (CORR_MAX_TRACK_EN) value of the largest result
module correlation_scheduler #(
    parameter int unsigned WIDTH          = 10,
    parameter bit          CLEAR_ON_START = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] ab_correlation_o,
    output logic [WIDTH-1:0] ac_correlation_o,
    output logic [WIDTH-1:0] bc_correlation_o
`ifdef CORR_MAX_TRACK_EN
    ,
    output logic [1:0]       max_pair_o,
    output logic [WIDTH-1:0] max_value_o
`endif
);

    typedef enum logic [2:0] {StIdle, StAb, StAc, StBc, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [WIDTH-1:0] a_d, b_d, c_d;
    logic [WIDTH-1:0] ab_q, ac_q, bc_q;
    logic [WIDTH-1:0] ab_d, ac_d, bc_d;
    logic [WIDTH-1:0] mux_x, mux_y, corr;
    logic             accept;

    // New work is only taken when nothing is in flight.
    assign accept = start_i && ((state_q == StIdle) || (state_q == StDone));

    correlator u_correlator (
        .a_i          (mux_x),
        .b_i          (mux_y),
        .correlation_o(corr)
    );

    // FSM next-state and Moore outputs.
    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        mux_x   = a_q;
        mux_y   = b_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StAb;
            end
            StAb: begin
                busy_o  = 1'b1;
                state_d = StAc;
            end
            StAc: begin
                busy_o  = 1'b1;
                mux_y   = c_q;
                state_d = StBc;
            end
            StBc: begin
                busy_o  = 1'b1;
                mux_x   = b_q;
                mux_y   = c_q;
                state_d = StDone;
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = accept ? StAb : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand and result next-state.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        c_d  = c_q;
        ab_d = ab_q;
        ac_d = ac_q;
        bc_d = bc_q;
        if (accept) begin
            a_d = a_i;
            b_d = b_i;
            c_d = c_i;
            if (CLEAR_ON_START) begin
                ab_d = '0;
                ac_d = '0;
                bc_d = '0;
            end
        end
        unique case (state_q)
            StAb:    ab_d = corr;
            StAc:    ac_d = corr;
            StBc:    bc_d = corr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            ab_q <= '0;
            ac_q <= '0;
            bc_q <= '0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            c_q  <= c_d;
            ab_q <= ab_d;
            ac_q <= ac_d;
            bc_q <= bc_d;
        end
    end

    assign ab_correlation_o = ab_q;
    assign ac_correlation_o = ac_q;
    assign bc_correlation_o = bc_q;

`ifdef CORR_MAX_TRACK_EN
    logic [WIDTH-1:0] run_val_q, run_val_d;
    logic [1:0]       run_pair_q, run_pair_d;
    logic [WIDTH-1:0] max_value_q, max_value_d;
    logic [1:0]       max_pair_q, max_pair_d;

    // Running maximum follows the results as they are captured. The final comparison happens
    // on the BC edge, so the outputs change together with done rising.
    // A strict '>' keeps ties on the lower index.
    always_comb begin
        run_val_d   = run_val_q;
        run_pair_d  = run_pair_q;
        max_value_d = max_value_q;
        max_pair_d  = max_pair_q;
        unique case (state_q)
            StAb: begin
                run_val_d  = corr;
                run_pair_d = 2'd0;
            end
            StAc: begin
                if (corr > run_val_q) begin
                    run_val_d  = corr;
                    run_pair_d = 2'd1;
                end
            end
            StBc: begin
                if (corr > run_val_q) begin
                    max_value_d = corr;
                    max_pair_d  = 2'd2;
                end else begin
                    max_value_d = run_val_q;
                    max_pair_d  = run_pair_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_val_q   <= '0;
            run_pair_q  <= '0;
            max_value_q <= '0;
            max_pair_q  <= '0;
        end else begin
            run_val_q   <= run_val_d;
            run_pair_q  <= run_pair_d;
            max_value_q <= max_value_d;
            max_pair_q  <= max_pair_d;
        end
    end

    assign max_pair_o  = max_pair_q;
    assign max_value_o = max_value_q;
`endif

endmodule

// File: tb/tb_correlation_scheduler.sv
// Self-checking bench for correlation_scheduler. dut0 uses the default parameters and has a
// result scoreboard. dut1 has CLEAR_ON_START=1 and checks clearing and max tracking.
module tb_correlation_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] a, b, c;
    logic       busy, done;
    logic [9:0] ab_o, ac_o, bc_o;
    logic       s_start;
    logic [9:0] s_a, s_b, s_c;
    logic       s_busy, s_done;
    logic [9:0] s_ab, s_ac, s_bc;
`ifdef CORR_MAX_TRACK_EN
    logic [1:0] max_pair, s_max_pair;
    logic [9:0] max_value, s_max_value;
`endif

    always #5 clk = ~clk;

    correlation_scheduler #(.WIDTH(10), .CLEAR_ON_START(1'b0)) dut0 (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start),
        .a_i             (a),
        .b_i             (b),
        .c_i             (c),
        .busy_o          (busy),
        .done_o          (done),
        .ab_correlation_o(ab_o),
        .ac_correlation_o(ac_o),
        .bc_correlation_o(bc_o)
`ifdef CORR_MAX_TRACK_EN
        ,
        .max_pair_o      (max_pair),
        .max_value_o     (max_value)
`endif
    );

    correlation_scheduler #(.WIDTH(10), .CLEAR_ON_START(1'b1)) dut1 (
        .clk             (clk),
        .reset           (reset),
        .start_i         (s_start),
        .a_i             (s_a),
        .b_i             (s_b),
        .c_i             (s_c),
        .busy_o          (s_busy),
        .done_o          (s_done),
        .ab_correlation_o(s_ab),
        .ac_correlation_o(s_ac),
        .bc_correlation_o(s_bc)
`ifdef CORR_MAX_TRACK_EN
        ,
        .max_pair_o      (s_max_pair),
        .max_value_o     (s_max_value)
`endif
    );

    typedef struct {
        logic [9:0] ab;
        logic [9:0] ac;
        logic [9:0] bc;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    // Independent reference: number of agreeing bit positions.
    function automatic logic [9:0] corr_model(input logic [9:0] x, input logic [9:0] y);
        return 10'($countones(~(x ^ y)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
        exp_t e;
        e.ab = corr_model(x, y);
        e.ac = corr_model(x, z);
        e.bc = corr_model(y, z);
        sb.push_back(e);
    endtask

    // One clock: inputs were driven at the previous negedge, outputs are sampled here.
    task automatic step();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                last_e = e;
                check("sb_ab", ab_o, e.ab);
                check("sb_ac", ac_o, e.ac);
                check("sb_bc", bc_o, e.bc);
                check("done_busy", busy, 0);
            end
        end
    endtask

    initial begin
        int lat;
        int d0;
        int n;
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        c       = '0;
        s_start = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_c     = '0;
        last_e  = '{ab: 10'd0, ac: 10'd0, bc: 10'd0};
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ab", ab_o, 0);
        check("rst_ac", ac_o, 0);
        check("rst_bc", bc_o, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Single run with latency check.
        a = 10'h3FF; b = 10'h000; c = 10'h155; start = 1'b1;
        push_exp(a, b, c);
        step();
        start = 1'b0;
        lat = 1;
        check("run_busy", busy, 1);
        while (done !== 1'b1 && lat < 8) begin
            step();
            lat++;
        end
        check("latency", lat, 4);
        step();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);

        // Operand isolation; results hold old values until overwritten.
        a = 10'h2C3; b = 10'h1A5; c = 10'h3C0; start = 1'b1;
        push_exp(a, b, c);
        step();
        start = 1'b0;
        check("hold_ac_on_start", ac_o, last_e.ac);
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 8) begin
            a = 10'h001; b = 10'h001; c = 10'h001;
            step();
            n++;
        end
        check("iso_done_seen", done_cnt - d0, 1);
        repeat (3) begin
            a = $urandom_range(0, 1023); b = $urandom_range(0, 1023); c = $urandom_range(0, 1023);
            step();
        end
        check("hold_ab", ab_o, last_e.ab);
        check("hold_bc", bc_o, last_e.bc);

        // Start while busy is ignored.
        d0 = done_cnt;
        a = 10'h0FF; b = 10'h3C3; c = 10'h111; start = 1'b1;
        push_exp(a, b, c);
        step();                                   // now AB
        a = 10'h3FF; b = 10'h3FF; c = 10'h3FF; start = 1'b1;
        step();                                   // AB edge ignored, now AC
        start = 1'b0;
        step();                                   // now BC
        a = 10'h2AA; b = 10'h155; c = 10'h000; start = 1'b1;
        step();                                   // BC edge ignored, now DONE
        start = 1'b0;
        repeat (4) step();
        check("busy_start_one_done", done_cnt - d0, 1);

        // Back-to-back with start held high.
        for (int i = 0; i < 12; i++) begin
            a = $urandom_range(0, 1023); b = $urandom_range(0, 1023); c = $urandom_range(0, 1023);
            start = 1'b1;
            if (i % 4 == 0) push_exp(a, b, c);
            step();
            check("b2b_done_cadence", done, (i % 4 == 3) ? 1 : 0);
        end
        start = 1'b0;
        step();
        check("b2b_sb_empty", sb.size(), 0);
        check("b2b_idle", busy, 0);

        // Asynchronous reset mid-AC.
        a = 10'h155; b = 10'h2AA; c = 10'h0F0; start = 1'b1;
        push_exp(a, b, c);
        step();
        start = 1'b0;
        step();                                   // now AC
        #2;
        reset = 1'b1;
        #1;
        check("areset_busy", busy, 0);
        check("areset_done", done, 0);
        check("areset_ab", ab_o, 0);
        check("areset_ac", ac_o, 0);
        check("areset_bc", bc_o, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (10) step();
        check("no_done_after_reset", done_cnt - d0, 0);

        // CLEAR_ON_START=1 instance.
        s_a = 10'h000; s_b = 10'h3FF; s_c = 10'h3F0; s_start = 1'b1;
        step();
        s_start = 1'b0;
        n = 0;
        while (s_done !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("clr_run1_done", s_done, 1);
        check("clr_run1_ab", s_ab, corr_model(10'h000, 10'h3FF));
        check("clr_run1_ac", s_ac, corr_model(10'h000, 10'h3F0));
        check("clr_run1_bc", s_bc, corr_model(10'h3FF, 10'h3F0));
`ifdef CORR_MAX_TRACK_EN
        check("max_pair_bc", s_max_pair, 2);
        check("max_value_bc", s_max_value, 6);
`endif
        step();
        s_a = 10'h2A5; s_b = 10'h2A5; s_c = 10'h2A5; s_start = 1'b1;
        step();
        s_start = 1'b0;
        check("clr_ab_zero", s_ab, 0);
        check("clr_ac_zero", s_ac, 0);
        check("clr_bc_zero", s_bc, 0);
        n = 0;
        while (s_done !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("clr_run2_done", s_done, 1);
        check("clr_run2_ab", s_ab, corr_model(10'h2A5, 10'h2A5));
        check("clr_run2_bc", s_bc, corr_model(10'h2A5, 10'h2A5));
`ifdef CORR_MAX_TRACK_EN
        check("max_pair_tie", s_max_pair, 0);
        check("max_value_tie", s_max_value, corr_model(10'h2A5, 10'h2A5));
`endif
        step();
        check("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
